// File: rtl/fetch_stage.sv
// Instruction fetch stage: program counter, single-outstanding imem requests and a
// 2-entry prefetch buffer feeding IF/ID. Optional macro FETCH_ALIGN_CHK_EN flags misaligned redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [5:0]  id_opcode,
  output logic [31:0] id_pc4,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic        req_r;
  logic [31:0] req_addr_r;

  logic [31:0] buf_instr_r [2];
  logic [31:0] buf_pc4_r   [2];
  logic        rd_ptr_r;
  logic        wr_ptr_r;
  logic [1:0]  cnt_r;

  logic        id_valid_r;
  logic [31:0] id_instr_r;
  logic [31:0] id_pc4_r;

  logic [31:0] target_s;
  logic        pop_s;
  logic        push_s;
  logic        issue_s;
  logic [31:0] push_pc4_s;
  logic [1:0]  cnt_after_s;
  logic [1:0]  cnt_nxt_s;
  logic        rd_ptr_nxt_s;
  logic        wr_ptr_nxt_s;
  logic [31:0] head_instr_s;
  logic [31:0] head_pc4_s;

  // Buffer handshake terms; the target is always forced to a word boundary.
  always_comb begin
    target_s    = redir_target & 32'hFFFF_FFFC;
    pop_s       = (cnt_r != 2'd0) && id_ready;
    push_s      = (state_r == S_WAIT) && imem_rvalid && !redir_valid;
    push_pc4_s  = req_addr_r + 32'd4;
    cnt_after_s = cnt_r + {1'b0, push_s} - {1'b0, pop_s};
  end

  // Request issue decision: needs room in the buffer and no redirect this edge.
  always_comb begin
    issue_s = 1'b0;
    case (state_r)
      S_FETCH: begin
        if (!redir_valid && (cnt_r < 2'd2)) begin
          issue_s = 1'b1;
        end else begin
          issue_s = 1'b0;
        end
      end
      S_WAIT: begin
        if (imem_rvalid && !redir_valid && (cnt_after_s < 2'd2)) begin
          issue_s = 1'b1;
        end else begin
          issue_s = 1'b0;
        end
      end
      S_DROP:  issue_s = 1'b0;
      default: issue_s = 1'b0;
    endcase
  end

  // Next buffer occupancy and pointers; a redirect empties the buffer regardless of pop.
  always_comb begin
    if (redir_valid) begin
      cnt_nxt_s    = 2'd0;
      rd_ptr_nxt_s = 1'b0;
      wr_ptr_nxt_s = 1'b0;
    end else begin
      cnt_nxt_s    = cnt_after_s;
      rd_ptr_nxt_s = rd_ptr_r ^ pop_s;
      wr_ptr_nxt_s = wr_ptr_r ^ push_s;
    end
  end

  // Next head entry, bypassing a word that lands in an otherwise empty slot.
  always_comb begin
    if (cnt_nxt_s == 2'd0) begin
      head_instr_s = 32'd0;
      head_pc4_s   = 32'd0;
    end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_instr_s = imem_rdata;
      head_pc4_s   = push_pc4_s;
    end else begin
      head_instr_s = buf_instr_r[rd_ptr_nxt_s];
      head_pc4_s   = buf_pc4_r[rd_ptr_nxt_s];
    end
  end

  // Fetch FSM together with the pc and the registered request outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_FETCH;
      pc_r       <= RESET_PC;
      req_r      <= 1'b0;
      req_addr_r <= RESET_PC;
    end else begin
      req_r <= issue_s;
      if (issue_s) begin
        req_addr_r <= pc_r;
      end
      if (redir_valid) begin
        pc_r <= target_s;
      end else if (issue_s) begin
        pc_r <= pc_r + 32'd4;
      end
      case (state_r)
        S_FETCH: begin
          if (issue_s) begin
            state_r <= S_WAIT;
          end else begin
            state_r <= S_FETCH;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state_r <= issue_s ? S_WAIT : S_FETCH;
          end else if (redir_valid) begin
            state_r <= S_DROP;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_DROP: begin
          // The outstanding response is consumed here even if a redirect coincides.
          if (imem_rvalid) begin
            state_r <= S_FETCH;
          end else begin
            state_r <= S_DROP;
          end
        end
        default: state_r <= S_FETCH;
      endcase
    end
  end

  // Prefetch buffer storage and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        buf_instr_r[i] <= 32'd0;
        buf_pc4_r[i]   <= 32'd0;
      end
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
    end else begin
      if (push_s) begin
        buf_instr_r[wr_ptr_r] <= imem_rdata;
        buf_pc4_r[wr_ptr_r]   <= push_pc4_s;
      end
      rd_ptr_r <= rd_ptr_nxt_s;
      wr_ptr_r <= wr_ptr_nxt_s;
      cnt_r    <= cnt_nxt_s;
    end
  end

  // IF/ID registers loaded from the next buffer head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid_r <= 1'b0;
      id_instr_r <= 32'd0;
      id_pc4_r   <= 32'd0;
    end else begin
      id_valid_r <= (cnt_nxt_s != 2'd0);
      id_instr_r <= head_instr_s;
      id_pc4_r   <= head_pc4_s;
    end
  end

`ifdef FETCH_ALIGN_CHK_EN
  logic err_r;

  // Sticky misaligned-redirect flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (redir_valid && (redir_target[1:0] != 2'b00)) begin
      err_r <= 1'b1;
    end
  end

  assign fetch_err = err_r;
`else
  assign fetch_err = 1'b0;
`endif

  assign imem_req  = req_r;
  assign imem_addr = req_addr_r;
  assign id_valid  = id_valid_r;
  assign id_instr  = id_instr_r;
  assign id_opcode = id_instr_r[31:26];
  assign id_pc4    = id_pc4_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: program-order reference stream, randomized memory latency,
// ready, redirects and resets, plus directed timing checks.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [5:0]  id_opcode;
  logic [31:0] id_pc4;
  logic        fetch_err;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redir_valid(redir_valid), .redir_target(redir_target),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_opcode(id_opcode), .id_pc4(id_pc4),
    .fetch_err(fetch_err)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_pc;
  logic        model_err;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_pops = 0;
  int          lat_min = 1;
  int          lat_max = 1;

  // Memory contents: address with a bit pattern folded into the opcode field.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ {a[7:2], 26'd0};
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Program-order reference: the stream restarts at the aligned target after a redirect.
  task automatic end_redirect();
    logic [31:0] t;
    t = redir_target;
    redir_valid = 1'b0;
    exp_q.delete();
    model_pc = t & 32'hFFFF_FFFC;
    if (ALIGN_CHK && (t[1:0] != 2'b00)) model_err = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] t);
    redir_valid  = 1'b1;
    redir_target = t;
    @(posedge clk); #2;
    end_redirect();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    model_pc  = RESET_PC;
    model_err = 1'b0;
    #1;
    check32("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check32("rst_imem_addr", imem_addr, RESET_PC);
    check32("rst_id_valid", {31'd0, id_valid}, 32'd0);
    check32("rst_id_instr", id_instr, 32'd0);
    check32("rst_id_pc4", id_pc4, 32'd0);
    check32("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    repeat (2) begin @(posedge clk); #2; end
    rst_n = 1'b1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; (i < 20) && !ok; i++) begin
      @(posedge clk); #2;
      if (imem_req) ok = 1'b1;
    end
  endtask

  // Instruction memory: one response per request after a random latency; reset cancels it.
  initial begin : memory
    bit          busy;
    int          cnt;
    logic [31:0] addr_q;
    busy = 1'b0; cnt = 0; addr_q = 32'd0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    forever begin
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      if (!rst_n) begin
        busy = 1'b0;
      end else begin
        if (busy) begin
          cnt--;
          if (cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(addr_q);
            busy = 1'b0;
          end
        end
        if (imem_req) begin
          check32("single_outstanding", {31'd0, busy}, 32'd0);
          busy   = 1'b1;
          addr_q = imem_addr;
          cnt    = $urandom_range(lat_max, lat_min);
        end
      end
    end
  end

  // Keeps the expected queue topped up from the reference program counter.
  initial begin : refill
    exp_t e;
    forever begin
      @(posedge clk); #3;
      while (exp_q.size() < 4) begin
        e.instr = mem_word(model_pc);
        e.pc4   = model_pc + 32'd4;
        exp_q.push_back(e);
        model_pc = model_pc + 32'd4;
      end
    end
  end

  // Monitor: pops and compares on every accepted IF/ID transfer.
  initial begin : monitor
    exp_t e;
    int   idle;
    idle = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        idle = 0;
      end else begin
        if (imem_req) check32("imem_addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
        check32("fetch_err", {31'd0, fetch_err}, {31'd0, model_err});
        if (redir_valid) begin
          idle = 0;
        end else if (id_valid && id_ready) begin
          idle = 0;
          n_pops++;
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_empty: got pc4 %h expected none", id_pc4);
          end else begin
            e = exp_q.pop_front();
            check32("id_pc4", id_pc4, e.pc4);
            check32("id_instr", id_instr, e.instr);
            check32("id_opcode", {26'd0, id_opcode}, {26'd0, e.instr[31:26]});
          end
        end else if (id_ready) begin
          idle++;
          if (idle == 40) begin
            n_checks++; n_fail++;
            $display("FAIL liveness: got %0d idle cycles expected below 40", idle);
          end
        end
      end
    end
  end

  initial begin : stimulus
    bit          ok;
    int          nreq;
    logic [31:0] t;
    rst_n = 1'b1; redir_valid = 1'b0; redir_target = 32'd0; id_ready = 1'b1;
    model_pc = RESET_PC; model_err = 1'b0;
    #2;
    do_reset();

    // First fetch timing with 1-cycle memory.
    @(posedge clk); #2;
    check32("c0_imem_req", {31'd0, imem_req}, 32'd1);
    check32("c0_imem_addr", imem_addr, RESET_PC);
    @(posedge clk); #2;
    check32("c1_imem_req", {31'd0, imem_req}, 32'd0);
    check32("c1_id_valid", {31'd0, id_valid}, 32'd0);
    @(posedge clk); #2;
    check32("c2_id_valid", {31'd0, id_valid}, 32'd1);
    check32("c2_id_instr", id_instr, 32'd0);
    check32("c2_id_opcode", {26'd0, id_opcode}, 32'd0);
    check32("c2_id_pc4", id_pc4, 32'd4);
    check32("c2_imem_addr", imem_addr, 32'd4);
    nreq = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (imem_req) nreq++;
    end
    check32("rate_half", nreq, 32'd10);

    // Decode stall: buffer fills to two entries and fetching stops.
    id_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      if (i >= 5) check32("stall_no_req", {31'd0, imem_req}, 32'd0);
    end
    check32("stall_id_valid", {31'd0, id_valid}, 32'd1);
    id_ready = 1'b1;
    wait_req(ok);
    check32("stall_resume_req", {31'd0, ok}, 32'd1);

    // Redirect while a 3-cycle response is outstanding.
    lat_min = 3; lat_max = 3;
    wait_req(ok);
    check32("wait_req_seen", {31'd0, ok}, 32'd1);
    redirect(32'h0000_0100);
    wait_req(ok);
    check32("redir_req_seen", {31'd0, ok}, 32'd1);
    check32("redir_imem_addr", imem_addr, 32'h0000_0100);
    ok = 1'b0;
    for (int i = 0; (i < 20) && !ok; i++) begin
      @(posedge clk); #2;
      if (id_valid) ok = 1'b1;
    end
    check32("redir_id_valid_seen", {31'd0, ok}, 32'd1);
    check32("redir_id_pc4", id_pc4, 32'h0000_0104);

    // Redirect coinciding with a response while the buffer holds an entry and pops.
    lat_min = 2; lat_max = 2;
    id_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; (i < 30) && !ok; i++) begin
      @(posedge clk); #2;
      if (imem_rvalid && id_valid) ok = 1'b1;
    end
    check32("coinc_rvalid_seen", {31'd0, ok}, 32'd1);
    id_ready = 1'b1;
    redirect(32'h0000_0200);
    check32("coinc_id_valid", {31'd0, id_valid}, 32'd0);
    check32("coinc_imem_req0", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #2;
    check32("coinc_imem_req1", {31'd0, imem_req}, 32'd1);
    check32("coinc_imem_addr", imem_addr, 32'h0000_0200);

    // pc wrap-around at the top of the address space.
    lat_min = 1; lat_max = 1;
    redirect(32'hFFFF_FFFC);
    wait_req(ok);
    check32("wrap_req_a", {31'd0, ok}, 32'd1);
    check32("wrap_addr_a", imem_addr, 32'hFFFF_FFFC);
    wait_req(ok);
    check32("wrap_req_b", {31'd0, ok}, 32'd1);
    check32("wrap_addr_b", imem_addr, 32'h0000_0000);

    // Misaligned redirect target.
    redirect(32'h0000_0103);
    check32("align_fetch_err", {31'd0, fetch_err}, {31'd0, ALIGN_CHK});
    wait_req(ok);
    check32("align_req_seen", {31'd0, ok}, 32'd1);
    check32("align_imem_addr", imem_addr, 32'h0000_0100);
    do_reset();

    // Randomized traffic.
    lat_min = 1; lat_max = 3;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #2;
      if (redir_valid) end_redirect();
      if ($urandom_range(999, 0) < 2) begin
        do_reset();
      end else begin
        id_ready = ($urandom_range(3, 0) != 0);
        if ($urandom_range(29, 0) == 0) begin
          t = $urandom;
          if ($urandom_range(3, 0) == 0) t = 32'hFFFF_FFF0 | (t & 32'h0000_000F);
          redir_valid  = 1'b1;
          redir_target = t;
        end
      end
    end
    @(posedge clk); #2;
    if (redir_valid) end_redirect();
    id_ready = 1'b1;
    repeat (20) begin @(posedge clk); #2; end
    check32("pop_count_min", {31'd0, (n_pops >= 200)}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
